traffic_light_controller: RTL and testbench

TRAFFIC_LIGHT_CONTROLLER -- requirements
Module: traffic_light_controller

---
 rtl/traffic_light_controller.sv | 148 ++++++++++++++
 tb/tb_traffic_light_controller.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/traffic_light_controller.sv
// Four-way traffic light sequencer with round-robin service and timed green/yellow/all-red phases.
// Optional long-queue green extension is enabled by defining TLC_EXT_GREEN_EN.
//
// state  | meaning
// IDLE   | all red, searching for demand every cycle
// GREEN  | served direction green for GREEN_TIME cycles
// EXT    | served direction green for EXT_TIME extra cycles (TLC_EXT_GREEN_EN only)
// YELLOW | served direction yellow for YELLOW_TIME cycles
// ALLRED | all red clearance for ALLRED_TIME cycles, then re-select
module traffic_light_controller #(
    parameter int GREEN_TIME  = 10,
    parameter int EXT_TIME    = 10,
    parameter int YELLOW_TIME = 3,
    parameter int ALLRED_TIME = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sensor_1th,
    input  logic [3:0] sensor_5th,
    output logic [1:0] Light_north,
    output logic [1:0] Light_south,
    output logic [1:0] Light_east,
    output logic [1:0] Light_west
);

    localparam int MAX_A   = (GREEN_TIME > EXT_TIME) ? GREEN_TIME : EXT_TIME;
    localparam int MAX_B   = (YELLOW_TIME > ALLRED_TIME) ? YELLOW_TIME : ALLRED_TIME;
    localparam int MAX_T   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int TIMER_W = ($clog2(MAX_T + 1) > 8) ? $clog2(MAX_T + 1) : 8;

    localparam logic [TIMER_W-1:0] GREEN_LOAD  = TIMER_W'(GREEN_TIME - 1);
    localparam logic [TIMER_W-1:0] YELLOW_LOAD = TIMER_W'(YELLOW_TIME - 1);
    localparam logic [TIMER_W-1:0] ALLRED_LOAD = TIMER_W'(ALLRED_TIME - 1);

`ifdef TLC_EXT_GREEN_EN
    localparam logic [TIMER_W-1:0] EXT_LOAD = TIMER_W'(EXT_TIME - 1);
    typedef enum logic [2:0] {IDLE, GREEN, EXT, YELLOW, ALLRED} state_t;
`else
    typedef enum logic [2:0] {IDLE, GREEN, YELLOW, ALLRED} state_t;
    logic unused_sensor_5th;
    assign unused_sensor_5th = ^sensor_5th;
`endif

    state_t             state, state_nxt;
    logic [TIMER_W-1:0] timer, timer_nxt;
    logic [1:0]         served, served_nxt;
    logic               sel_found;
    logic [1:0]         sel_dir;
    logic [1:0]         cand;
    logic               timer_tc;
    logic [1:0]         color;

    assign timer_tc = (timer == '0);

    // Round-robin search starting after the last served direction; served is checked last.
    always_comb begin
        sel_found = 1'b0;
        sel_dir   = served;
        cand      = served;
        for (int k = 1; k <= 4; k++) begin
            cand = served + 2'(k);
            if (!sel_found && sensor_1th[cand]) begin
                sel_found = 1'b1;
                sel_dir   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            timer  <= '0;
            served <= 2'd3;
        end else begin
            state  <= state_nxt;
            timer  <= timer_nxt;
            served <= served_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        timer_nxt  = timer - 1'b1;
        served_nxt = served;
        case (state)
            GREEN: begin
                if (timer_tc) begin
`ifdef TLC_EXT_GREEN_EN
                    if (sensor_5th[served]) begin
                        state_nxt = EXT;
                        timer_nxt = EXT_LOAD;
                    end else begin
                        state_nxt = YELLOW;
                        timer_nxt = YELLOW_LOAD;
                    end
`else
                    state_nxt = YELLOW;
                    timer_nxt = YELLOW_LOAD;
`endif
                end
            end
`ifdef TLC_EXT_GREEN_EN
            EXT: begin
                if (timer_tc) begin
                    state_nxt = YELLOW;
                    timer_nxt = YELLOW_LOAD;
                end
            end
`endif
            YELLOW: begin
                if (timer_tc) begin
                    state_nxt = ALLRED;
                    timer_nxt = ALLRED_LOAD;
                end
            end
            default: begin
                // IDLE every cycle, ALLRED only on its terminal count
                if (state == IDLE || timer_tc) begin
                    if (sel_found) begin
                        state_nxt  = GREEN;
                        timer_nxt  = GREEN_LOAD;
                        served_nxt = sel_dir;
                    end else begin
                        state_nxt = IDLE;
                        timer_nxt = '0;
                    end
                end
            end
        endcase
    end

    always_comb begin
        color = 2'b00;
        case (state)
            GREEN:   color = 2'b10;
`ifdef TLC_EXT_GREEN_EN
            EXT:     color = 2'b10;
`endif
            YELLOW:  color = 2'b01;
            default: color = 2'b00;
        endcase
        Light_north = (served == 2'd0) ? color : 2'b00;
        Light_south = (served == 2'd1) ? color : 2'b00;
        Light_east  = (served == 2'd2) ? color : 2'b00;
        Light_west  = (served == 2'd3) ? color : 2'b00;
    end

endmodule

// File: tb/tb_traffic_light_controller.sv
// Scoreboard bench for traffic_light_controller: a phase-plan reference model queues the expected
// light word for every cycle, and an independent monitor compares it against the DUT outputs.
module tb_traffic_light_controller;

    localparam int G_T = 10;
    localparam int E_T = 10;
    localparam int Y_T = 3;
    localparam int A_T = 1;
`ifdef TLC_EXT_GREEN_EN
    localparam bit EXT_EN = 1'b1;
`else
    localparam bit EXT_EN = 1'b0;
`endif

    localparam int T_IDLE = 0;
    localparam int T_GRN  = 1;
    localparam int T_EXT  = 2;
    localparam int T_YEL  = 3;
    localparam int T_RED  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] s1  = 4'b0000;
    logic [3:0] s5  = 4'b0000;
    logic [1:0] ln, ls, le, lw;

    always #5 clk = ~clk;

    traffic_light_controller #(
        .GREEN_TIME (G_T),
        .EXT_TIME   (E_T),
        .YELLOW_TIME(Y_T),
        .ALLRED_TIME(A_T)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sensor_1th (s1),
        .sensor_5th (s5),
        .Light_north(ln),
        .Light_south(ls),
        .Light_east (le),
        .Light_west (lw)
    );

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] exp_q[$];

    // Reference model: a plan of upcoming phase cycles; a new phase is planned when the plan runs dry.
    int plan[$];
    int cur_tag = T_IDLE;
    int served  = 3;

    function automatic logic [7:0] word_of(int tag, int dir);
        logic [7:0] w;
        logic [1:0] c;
        c = (tag == T_GRN || tag == T_EXT) ? 2'b10 : (tag == T_YEL) ? 2'b01 : 2'b00;
        w = 8'h00;
        w[2*dir +: 2] = c;
        return w;
    endfunction

    task automatic model_step(input bit r, input logic [3:0] a, input logic [3:0] b);
        int d;
        bit found;
        if (!r) begin
            plan.delete();
            cur_tag = T_IDLE;
            served  = 3;
            return;
        end
        if (plan.size() == 0) begin
            case (cur_tag)
                T_GRN: begin
                    if (EXT_EN && b[served])
                        repeat (E_T) plan.push_back(T_EXT);
                    else
                        repeat (Y_T) plan.push_back(T_YEL);
                end
                T_EXT: repeat (Y_T) plan.push_back(T_YEL);
                T_YEL: repeat (A_T) plan.push_back(T_RED);
                default: begin
                    found = 1'b0;
                    for (int k = 1; k <= 4; k++) begin
                        d = (served + k) % 4;
                        if (!found && a[d]) begin
                            found  = 1'b1;
                            served = d;
                        end
                    end
                    if (found) repeat (G_T) plan.push_back(T_GRN);
                end
            endcase
        end
        if (plan.size() > 0) cur_tag = plan.pop_front();
        else cur_tag = T_IDLE;
    endtask

    task automatic drive(input bit r, input logic [3:0] a, input logic [3:0] b, input int n);
        repeat (n) begin
            @(negedge clk);
            rst = r;
            s1  = a;
            s5  = b;
            model_step(r, a, b);
            exp_q.push_back(word_of(cur_tag, served));
        end
    endtask

    initial begin
        logic [7:0] e;
        logic [7:0] act;
        int         nonred;
        bit         bad_code;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {lw, le, ls, ln};
                vectors++;
                if (act !== e) begin
                    miscompares++;
                    $display("FAIL lights at %0t: got W/E/S/N=%b required %b", $time, act, e);
                end
                nonred   = 0;
                bad_code = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    if (act[2*i +: 2] != 2'b00) nonred++;
                    if (act[2*i +: 2] == 2'b11) bad_code = 1'b1;
                end
                vectors++;
                if (nonred > 1 || bad_code) begin
                    miscompares++;
                    $display("FAIL exclusivity at %0t: got %0d non-red lights (word %b) required at most 1, no 11",
                             $time, nonred, act);
                end
            end
        end
    end

    initial begin
        int seg_len;
        // held in reset with arbitrary sensors, then idle with no demand
        for (int i = 0; i < 20; i++) drive(1'b0, 4'($urandom), 4'($urandom), 1);
        drive(1'b1, 4'b0000, 4'b0000, 5);
        // single direction, no long queue, then long queue
        drive(1'b1, 4'b0001, 4'b0000, 30);
        drive(1'b1, 4'b0001, 4'b0001, 40);
        // two-way alternation
        drive(1'b1, 4'b0011, 4'b0000, 60);
        // service order from a fresh reset
        drive(1'b0, 4'b0000, 4'b0000, 1);
        drive(1'b1, 4'b1011, 4'b0000, 60);
        drive(1'b1, 4'b1100, 4'b1010, 80);
        // reset pulse mid north green, then full restart
        drive(1'b0, 4'b0000, 4'b0000, 2);
        drive(1'b1, 4'b0001, 4'b0000, 4);
        drive(1'b0, 4'b0001, 4'b0000, 1);
        drive(1'b1, 4'b0001, 4'b0000, 20);
        // randomized segments, including sensors dropping mid-phase and occasional resets
        repeat (80) begin
            seg_len = $urandom_range(1, 30);
            if ($urandom_range(0, 11) == 0)
                drive(1'b0, 4'($urandom), 4'($urandom), $urandom_range(1, 3));
            drive(1'b1, 4'($urandom), 4'($urandom), seg_len);
        end
        @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d unchecked entries required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
